// File: rtl/pc_gen_pkg.sv
// Shared next-PC select codes, redirect classes and default vectors
// for the fetch-stage PC generator.
package pc_gen_pkg;

    localparam logic [2:0] NPC_PC4    = 3'd0;
    localparam logic [2:0] NPC_ADDR   = 3'd1;
    localparam logic [2:0] NPC_REG    = 3'd2;
    localparam logic [2:0] NPC_BRANCH = 3'd3;

    localparam logic [1:0] CLS_NONE = 2'd0;
    localparam logic [1:0] CLS_D    = 2'd1;
    localparam logic [1:0] CLS_ERET = 2'd2;
    localparam logic [1:0] CLS_REQ  = 2'd3;

    localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
    localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;
    localparam logic [31:0] IM_BASE_DEF    = 32'h0000_3000;
    localparam logic [31:0] IM_LIMIT_DEF   = 32'h0000_6FFC;

endpackage

// File: rtl/pc_gen_npc_target.sv
// Combinational redirect resolver: picks the highest-priority
// redirect among CP0 request, ERET and the D-stage jump/branch.
module npc_target
    import pc_gen_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter logic [ADDR_W-1:0] HANDLER_PC = HANDLER_PC_DEF,
    parameter logic [ADDR_W-1:0] ERET_ADJ = '0
) (
    input  logic              stall,
    input  logic [ADDR_W-1:0] d_pc,
    input  logic [25:0]       imm26,
    input  logic [ADDR_W-1:0] rs_val,
    input  logic [2:0]        npc_sel,
    input  logic              br_taken,
    input  logic              req,
    input  logic              eret,
    input  logic [ADDR_W-1:0] epc,
    output logic              rd_valid,
    output logic [ADDR_W-1:0] rd_tgt,
    output logic [1:0]        rd_cls
);

    logic [ADDR_W-1:0] j_tgt;
    logic [ADDR_W-1:0] b_tgt;
    logic [ADDR_W-1:0] b_off;
    logic [ADDR_W-1:0] e_tgt;
    logic [ADDR_W-1:0] d_tgt;
    logic              d_hit;

    assign j_tgt = {d_pc[ADDR_W-1:28], imm26, 2'b00};
    assign b_off = {{(ADDR_W-18){imm26[15]}}, imm26[15:0], 2'b00};
    assign b_tgt = d_pc + ADDR_W'(4) + b_off;
    assign e_tgt = epc + ERET_ADJ;

    always_comb begin
        d_hit = 1'b0;
        d_tgt = '0;
        unique case (npc_sel)
            NPC_ADDR: begin
                d_hit = 1'b1;
                d_tgt = j_tgt;
            end
            NPC_REG: begin
                d_hit = 1'b1;
                d_tgt = rs_val;
            end
            NPC_BRANCH: begin
                d_hit = br_taken;
                d_tgt = b_tgt;
            end
            default: ;
        endcase
    end

    // Conditions are made mutually exclusive so the one-hot
    // decode also encodes the priority order.
    always_comb begin
        rd_valid = 1'b0;
        rd_tgt   = '0;
        rd_cls   = CLS_NONE;
        unique case (1'b1)
            req: begin
                rd_valid = 1'b1;
                rd_tgt   = HANDLER_PC;
                rd_cls   = CLS_REQ;
            end
            (!req && eret): begin
                rd_valid = 1'b1;
                rd_tgt   = e_tgt;
                rd_cls   = CLS_ERET;
            end
            (!req && !eret && !stall && d_hit): begin
                rd_valid = 1'b1;
                rd_tgt   = d_tgt;
                rd_cls   = CLS_D;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage PC register with imem handshake, one-entry
// pending-redirect latch and fetch address-error flag.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [ADDR_W-1:0] HANDLER_PC = HANDLER_PC_DEF,
    parameter logic [ADDR_W-1:0] ERET_ADJ   = '0,
    parameter logic [ADDR_W-1:0] IM_BASE    = IM_BASE_DEF,
    parameter logic [ADDR_W-1:0] IM_LIMIT   = IM_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              imem_ready,
    input  logic [ADDR_W-1:0] d_pc,
    input  logic [25:0]       imm26,
    input  logic [ADDR_W-1:0] rs_val,
    input  logic [2:0]        npc_sel,
    input  logic              br_taken,
    input  logic              req,
    input  logic              eret,
    input  logic [ADDR_W-1:0] epc,
    output logic [ADDR_W-1:0] f_pc,
    output logic              f_adel,
    output logic              pend_valid
);

    logic              rd_valid;
    logic [ADDR_W-1:0] rd_tgt;
    logic [1:0]        rd_cls;
    logic [ADDR_W-1:0] pend_tgt;
    logic [1:0]        pend_cls;
    logic              pend_take;

    npc_target #(
        .ADDR_W     (ADDR_W),
        .HANDLER_PC (HANDLER_PC),
        .ERET_ADJ   (ERET_ADJ)
    ) u_npc_target (
        .stall    (stall),
        .d_pc     (d_pc),
        .imm26    (imm26),
        .rs_val   (rs_val),
        .npc_sel  (npc_sel),
        .br_taken (br_taken),
        .req      (req),
        .eret     (eret),
        .epc      (epc),
        .rd_valid (rd_valid),
        .rd_tgt   (rd_tgt),
        .rd_cls   (rd_cls)
    );

    // Equal class replaces the latch so the newest target wins.
    assign pend_take = rd_valid &&
                       (!pend_valid || (rd_cls >= pend_cls));

    always_ff @(posedge clk) begin
        if (reset) begin
            f_pc       <= RESET_PC;
            pend_valid <= 1'b0;
            pend_tgt   <= '0;
            pend_cls   <= CLS_NONE;
        end else if (imem_ready) begin
            if (rd_valid) begin
                f_pc <= rd_tgt;
            end else if (pend_valid) begin
                f_pc <= pend_tgt;
            end else if (!stall) begin
                f_pc <= f_pc + ADDR_W'(4);
            end
            pend_valid <= 1'b0;
            pend_cls   <= CLS_NONE;
        end else if (pend_take) begin
            pend_valid <= 1'b1;
            pend_tgt   <= rd_tgt;
            pend_cls   <= rd_cls;
        end
    end

    assign f_adel = (f_pc[1:0] != 2'b00) ||
                    (f_pc < IM_BASE) ||
                    (f_pc > IM_LIMIT);

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: directed plan plus randomized
// traffic against a behavioural next-PC model.
module tb_pc_gen;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        imem_ready;
    logic [31:0] d_pc;
    logic [25:0] imm26;
    logic [31:0] rs_val;
    logic [2:0]  npc_sel;
    logic        br_taken;
    logic        req;
    logic        eret;
    logic [31:0] epc;
    logic [31:0] f_pc;
    logic        f_adel;
    logic        pend_valid;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [31:0] pc;
        logic        adel;
        logic        pend;
    } exp_t;

    exp_t sb_q[$];

    logic [31:0] m_pc;
    logic        m_pend;
    logic [31:0] m_ptgt;
    int          m_pcls;

    pc_gen dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .imem_ready (imem_ready),
        .d_pc       (d_pc),
        .imm26      (imm26),
        .rs_val     (rs_val),
        .npc_sel    (npc_sel),
        .br_taken   (br_taken),
        .req        (req),
        .eret       (eret),
        .epc        (epc),
        .f_pc       (f_pc),
        .f_adel     (f_adel),
        .pend_valid (pend_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic bad_addr(logic [31:0] a);
        return (a % 4 != 0) || (a < 32'h3000) || (a > 32'h6FFC);
    endfunction

    task automatic check(string name, logic [31:0] act,
                         logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference: apply the redirect rules to the current inputs
    // and predict the state visible after the next clock edge.
    task automatic model_step();
        bit          rv;
        logic [31:0] rt;
        int          rc;
        int          off;
        exp_t        e;
        rv = 0;
        rt = 0;
        rc = 0;
        if (reset) begin
            m_pc   = 32'h3000;
            m_pend = 0;
            m_ptgt = 0;
            m_pcls = 0;
        end else begin
            if (req) begin
                rv = 1; rt = 32'h4180; rc = 3;
            end else if (eret) begin
                rv = 1; rt = epc; rc = 2;
            end else if (!stall) begin
                if (npc_sel == 3'd1) begin
                    rv = 1; rc = 1;
                    rt = {4'b0, imm26, 2'b00} | (d_pc & 32'hF000_0000);
                end else if (npc_sel == 3'd2) begin
                    rv = 1; rc = 1; rt = rs_val;
                end else if (npc_sel == 3'd3 && br_taken) begin
                    off = $signed(imm26[15:0]);
                    rv = 1; rc = 1;
                    rt = d_pc + 4 + 32'(off * 4);
                end
            end
            if (imem_ready) begin
                if (rv) m_pc = rt;
                else if (m_pend) m_pc = m_ptgt;
                else if (!stall) m_pc = m_pc + 4;
                m_pend = 0;
            end else if (rv && (!m_pend || rc >= m_pcls)) begin
                m_pend = 1;
                m_ptgt = rt;
                m_pcls = rc;
            end
        end
        e.pc   = m_pc;
        e.adel = bad_addr(m_pc);
        e.pend = m_pend;
        sb_q.push_back(e);
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        reset      = 0;
        stall      = 0;
        imem_ready = 1;
        d_pc       = 32'h3000;
        imm26      = 0;
        rs_val     = 0;
        npc_sel    = 3'd0;
        br_taken   = 0;
        req        = 0;
        eret       = 0;
        epc        = 0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                total++;
                if (f_pc !== e.pc || f_adel !== e.adel ||
                    pend_valid !== e.pend) begin
                    bad++;
                    $display("FAIL sb: got pc=%h adel=%b pend=%b want pc=%h adel=%b pend=%b",
                             f_pc, f_adel, pend_valid,
                             e.pc, e.adel, e.pend);
                end
            end
        end
    end

    initial begin : stim
        idle_inputs();
        reset = 1;
        @(negedge clk);
        tick();
        check("reset_pc", f_pc, 32'h3000);
        check("reset_adel", 32'(f_adel), 0);
        check("reset_pend", 32'(pend_valid), 0);
        reset = 0;
        tick();
        check("seq1", f_pc, 32'h3004);
        tick();
        tick();
        check("seq3", f_pc, 32'h300C);

        d_pc = 32'h3010; npc_sel = 3'd3;
        imm26 = 26'h000FFFC; br_taken = 1;
        tick();
        check("br_taken", f_pc, 32'h3004);
        br_taken = 0;
        tick();
        check("br_not_taken", f_pc, 32'h3008);

        d_pc = 32'h3020; npc_sel = 3'd1; imm26 = 26'h0000C10;
        tick();
        check("jal", f_pc, 32'h3040);
        req = 1;
        tick();
        check("req_wins", f_pc, 32'h4180);
        req = 0;

        imem_ready = 0; imm26 = 26'h0000C40;
        tick();
        npc_sel = 3'd0; eret = 1; epc = 32'h3200;
        tick();
        eret = 0;
        tick();
        check("pend_hold_pc", f_pc, 32'h4180);
        check("pend_set", 32'(pend_valid), 1);
        imem_ready = 1;
        tick();
        check("pend_eret", f_pc, 32'h3200);
        check("pend_clr", 32'(pend_valid), 0);

        imem_ready = 0; req = 1;
        tick();
        req = 0; npc_sel = 3'd1;
        tick();
        npc_sel = 3'd0;
        tick();
        imem_ready = 1;
        tick();
        check("pend_req_kept", f_pc, 32'h4180);

        tick();
        stall = 1; npc_sel = 3'd2; rs_val = 32'h3400;
        tick();
        check("stall_hold", f_pc, 32'h4184);
        req = 1;
        tick();
        check("stall_req", f_pc, 32'h4180);
        req = 0; stall = 0;

        rs_val = 32'h3402;
        tick();
        check("adel_misalign", 32'(f_adel), 1);
        rs_val = 32'h7000;
        tick();
        check("adel_limit", 32'(f_adel), 1);
        rs_val = 32'h6FFC;
        tick();
        check("adel_edge_ok", 32'(f_adel), 0);
        rs_val = 32'hFFFF_FFFC;
        tick();
        npc_sel = 3'd0;
        tick();
        check("wrap", f_pc, 32'h0);
        check("wrap_adel", 32'(f_adel), 1);

        imem_ready = 0; npc_sel = 3'd2; rs_val = 32'h3500;
        tick();
        reset = 1;
        tick();
        check("rst_pend_pc", f_pc, 32'h3000);
        check("rst_pend_clr", 32'(pend_valid), 0);
        reset = 0;

        for (int i = 0; i < 400; i++) begin
            reset      = ($urandom_range(0, 99) == 0);
            stall      = ($urandom_range(0, 4) == 0);
            imem_ready = ($urandom_range(0, 9) < 7);
            d_pc       = 32'h3000 + ($urandom_range(0, 4095) << 2);
            imm26      = 26'($urandom);
            npc_sel    = 3'($urandom_range(0, 7));
            br_taken   = 1'($urandom);
            req        = ($urandom_range(0, 9) == 0);
            eret       = ($urandom_range(0, 9) == 0);
            epc        = 32'h3000 + ($urandom_range(0, 4095) << 2);
            if ($urandom_range(0, 3) == 0) rs_val = $urandom;
            else rs_val = 32'h3000 + ($urandom_range(0, 4095) << 2);
            tick();
        end

        idle_inputs();
        tick();
        tick();
        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sb_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
